muldiv_unit: RTL and testbench



---
 rtl/muldiv_unit.sv | 200 ++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit for the execute stage.
// Ports: clk, rst_n (async active-low); in_valid/in_ready + op/A/B operand
//   handshake; kill flush; out_valid/out_ready + result output handshake;
//   busy high while an operation is in flight (CALC or DONE).
// Optional build macro MULDIV_FAST_MUL_EN: single-cycle multiplies.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic            kill,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [XLEN-1:0]  hi_q, hi_d;
    logic [XLEN-1:0]  lo_q, lo_d;
    logic [XLEN-1:0]  md_q, md_d;
    logic             neg_q, neg_d;
    logic             rneg_q, rneg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  res_q, res_d;

    // Operand decode at accept time
    logic            is_div;
    logic            a_sgn, b_sgn;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            b_zero, ovf, special;
    logic [XLEN-1:0] spec_res;
    logic            fast;
    logic [XLEN-1:0] fast_res;
    logic            accept;

    assign is_div = op[2];
    // MUL low half is sign-agnostic, so it runs unsigned
    assign a_sgn = is_div ? ~op[0] : (op[1:0] == 2'b01 || op[1:0] == 2'b10);
    assign b_sgn = is_div ? ~op[0] : (op[1:0] == 2'b01);
    assign a_neg = a_sgn & A[XLEN-1];
    assign b_neg = b_sgn & B[XLEN-1];
    assign a_mag = a_neg ? -A : A;
    assign b_mag = b_neg ? -B : B;

    assign b_zero  = (B == '0);
    assign ovf     = ~op[0] & (A == {1'b1, {(XLEN-1){1'b0}}}) & (&B);
    assign special = is_div & (b_zero | ovf);
    // Overflow: quotient is A (MIN_INT) and remainder is zero
    assign spec_res = b_zero ? (op[1] ? A : '1) : (op[1] ? '0 : A);

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] a_ext, b_ext, fprod;
    assign a_ext    = {{XLEN{a_sgn & A[XLEN-1]}}, A};
    assign b_ext    = {{XLEN{b_sgn & B[XLEN-1]}}, B};
    assign fprod    = a_ext * b_ext;
    assign fast     = ~is_div;
    assign fast_res = (op[1:0] == 2'b00) ? fprod[XLEN-1:0]
                                         : fprod[2*XLEN-1:XLEN];
`else
    assign fast     = 1'b0;
    assign fast_res = '0;
`endif

    assign accept = in_valid & in_ready & ~kill;

    // One iteration: shift-add multiply or restoring divide step.
    // Multiply keeps the product in {hi,lo} with the multiplier in lo;
    // divide keeps the partial remainder in hi, dividend/quotient in lo.
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_sh, div_diff;
    logic            div_ok;
    logic [XLEN-1:0] hi_n, lo_n;

    assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, md_q} : '0);
    assign div_sh   = {hi_q, lo_q[XLEN-1]};
    assign div_diff = div_sh - {1'b0, md_q};
    assign div_ok   = ~div_diff[XLEN];

    always_comb begin
        if (op_q[2]) begin
            hi_n = div_ok ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0];
            lo_n = {lo_q[XLEN-2:0], div_ok};
        end else begin
            {hi_n, lo_n} = {mul_sum, lo_q[XLEN-1:1]};
        end
    end

    // Sign fix-up applied to the final iteration's outputs
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   quo, rem, fin;

    assign prod   = {hi_n, lo_n};
    assign prod_s = neg_q ? -prod : prod;
    assign quo    = neg_q ? -lo_n : lo_n;
    assign rem    = rneg_q ? -hi_n : hi_n;

    always_comb begin
        if (op_q[2])
            fin = op_q[1] ? rem : quo;
        else if (op_q[1:0] == 2'b00)
            fin = prod_s[XLEN-1:0];
        else
            fin = prod_s[2*XLEN-1:XLEN];
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        md_d    = md_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d   = op;
                    neg_d  = a_neg ^ b_neg;
                    rneg_d = a_neg;
                    cnt_d  = '0;
                    hi_d   = '0;
                    lo_d   = is_div ? a_mag : b_mag;
                    md_d   = is_div ? b_mag : a_mag;
                    if (special) begin
                        res_d   = spec_res;
                        state_d = S_DONE;
                    end else if (fast) begin
                        res_d   = fast_res;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (kill) begin
                    state_d = S_IDLE;
                end else begin
                    hi_d  = hi_n;
                    lo_d  = lo_n;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(XLEN - 1)) begin
                        res_d   = fin;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (kill || out_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            md_q    <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            md_q    <= md_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_CALC) || (state_q == S_DONE);
    assign result    = res_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized + directed bench for muldiv_unit (XLEN=32)
// against a plain-arithmetic RV32M reference model.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        kill;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        busy;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] MIN = 32'h8000_0000;

    muldiv_unit #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .A         (A),
        .B         (B),
        .kill      (kill),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] o,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] ae, be, p;
        int sa, sb;
        int unsigned ua, ub;
        sa = a; sb = b; ua = a; ub = b;
        case (o)
            3'd0: begin
                p = {32'b0, a} * {32'b0, b};
                return p[31:0];
            end
            3'd1: begin
                ae = {{32{a[31]}}, a}; be = {{32{b[31]}}, b};
                p = ae * be;
                return p[63:32];
            end
            3'd2: begin
                ae = {{32{a[31]}}, a}; be = {32'b0, b};
                p = ae * be;
                return p[63:32];
            end
            3'd3: begin
                p = {32'b0, a} * {32'b0, b};
                return p[63:32];
            end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MIN && b == 32'hFFFF_FFFF) return MIN;
                return 32'(sa / sb);
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return 32'(ua / ub);
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == MIN && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(sa % sb);
            end
            default: begin
                if (b == 0) return a;
                return 32'(ua % ub);
            end
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] o,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
        if (o[2] && (b == 0 || (!o[0] && a == MIN && b == 32'hFFFF_FFFF)))
            return 1;
`ifdef MULDIV_FAST_MUL_EN
        if (!o[2]) return 1;
`endif
        return 33;
    endfunction

    // Launch one op, time it, check it, hold it for 'hold' cycles, drain it.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] want,
                          input int hold);
        int lat;
        int rdy;
        chk("idle_rdy", 64'(in_ready), 64'd1);
        op = o; A = a; B = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        A = $urandom; B = $urandom; op = 3'($urandom);
        chk("busy", 64'(busy), 64'd1);
        lat = 1;
        rdy = 0;
        while (!out_valid && lat < 100) begin
            if (in_ready) rdy++;
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 64'(lat), 64'(exp_lat(o, a, b)));
        chk("result", 64'(result), 64'(want));
        chk("rdy_low", 64'(rdy), 64'd0);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom);
            A = $urandom; B = $urandom;
            @(posedge clk); #1;
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_result", 64'(result), 64'(want));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("post_rdy", 64'(in_ready), 64'd1);
        chk("post_valid", 64'(out_valid), 64'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return MIN;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int seen;
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        kill = 1'b0; op = '0; A = '0; B = '0;
        #12;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(3'd0, 32'd7, 32'd6, 32'd42, 0);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
        run_op(3'd1, MIN, MIN, 32'h4000_0000, 0);
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 0);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0);
        run_op(3'd5, 32'd100, 32'd7, 32'd14, 0);
        run_op(3'd7, 32'd100, 32'd7, 32'd2, 0);
        run_op(3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
        run_op(3'd7, 32'd5, 32'd0, 32'd5, 0);
        run_op(3'd4, MIN, 32'hFFFF_FFFF, MIN, 0);
        run_op(3'd6, MIN, 32'hFFFF_FFFF, 32'd0, 0);
        run_op(3'd5, 32'd100, 32'd7, 32'd14, 10);

        // kill at iteration 10 of MUL 3x5
        op = 3'd0; A = 32'd3; B = 32'd5; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1 kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        chk("kill_rdy", 64'(in_ready), 64'd1);
        chk("kill_busy", 64'(busy), 64'd0);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("kill_no_valid", 64'(seen), 64'd0);

        // kill beats in_valid in IDLE
        op = 3'd0; A = 32'd1; B = 32'd1; in_valid = 1'b1; kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0; in_valid = 1'b0;
        chk("kidle_rdy", 64'(in_ready), 64'd1);
        chk("kidle_busy", 64'(busy), 64'd0);

        // async reset mid-CALC
        op = 3'd5; A = 32'd100; B = 32'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #2;
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_result", 64'(result), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(3'd0, 32'd3, 32'd5, 32'd15, 0);

        for (int n = 0; n < 150; n++) begin
            ro = 3'($urandom);
            ra = pick();
            rb = pick();
            run_op(ro, ra, rb, model(ro, ra, rb), $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
